pmt_scheduler: RTL and testbench

Clocked permit scheduler for a bank of pmt-gated click FIFO stages sharing one downstream resource. It arbitrates round-robin among N requesters and raises exactly one `o_pmt` line at a time. It holds that permit until the granted stage reports one completed transfer through its 2-phase toggle, then drops the permit for a guard cycle. Sits between the synchronous control domain and the self-timed pipeline.

---
 rtl/pmt_sched_pkg.sv | 21 ++
 rtl/pmt_ack_sync.sv | 46 ++++
 rtl/pmt_scheduler.sv | 179 +++++++++++++++++
 tb/tb_pmt_scheduler.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pmt_sched_pkg.sv
// pmt_sched_pkg
// Shared definitions for the pmt permit scheduler:
//   - pmt_state_e     : scheduler FSM states
//   - PMT_SCHED_CNT_W : width of the permit-hold cycle counter
//   - pmt_gnt_w()     : width of the grant index for a given requester count
package pmt_sched_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RELEASE = 2'd2
  } pmt_state_e;

  localparam int PMT_SCHED_CNT_W = 16;

  // Index width for n requesters; never below one bit.
  function automatic int pmt_gnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pmt_ack_sync.sv
// pmt_ack_sync
// Brings one asynchronous 2-phase completion toggle into the clk domain and
// turns each edge of it into a single-cycle done pulse.
// Ports:
//   clk    : clock
//   rst    : asynchronous active-low reset (chain and phase restart at 0)
//   i_tgl  : asynchronous toggle from the pipeline stage
//   o_done : registered one-cycle pulse, SYNC_STAGES+1 edges after a toggle
module pmt_ack_sync
  import pmt_sched_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_tgl,
  output logic o_done
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   phase_q, phase_d;
  logic                   done_q, done_d;

  // The phase register simply trails the synchronized level by one cycle,
  // so any difference between the two marks exactly one toggle.
  always_comb begin
    sync_d  = {sync_q[SYNC_STAGES-2:0], i_tgl};
    phase_d = sync_q[SYNC_STAGES-1];
    done_d  = sync_q[SYNC_STAGES-1] ^ phase_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q  <= '0;
      phase_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      phase_q <= phase_d;
      done_q  <= done_d;
    end
  end

  assign o_done = done_q;

endmodule

// File: rtl/pmt_scheduler.sv
// pmt_scheduler
// Round-robin permit scheduler for N pmt-gated click FIFO stages sharing one
// downstream resource. One o_pmt line is raised at a time and held until the
// granted stage reports a completed transfer on its 2-phase ack toggle, then
// the permit is dropped for one guard cycle before the next arbitration.
//
// Optional feature: define PMT_SCHED_TIMEOUT_EN to add the permit-hold
// counter that aborts a permit after TIMEOUT cycles and pulses o_timeout.
// Without it GRANT waits indefinitely and o_timeout is constant 0.
//
// Ports:
//   clk        : clock, all state on the rising edge
//   rst        : asynchronous active-low reset
//   i_req      : [N] synchronous level request per stage
//   i_ack_tgl  : [N] asynchronous 2-phase completion toggle per stage
//   o_pmt      : [N] registered one-hot-or-zero permit
//   o_gnt_id   : index of current/last grant
//   o_busy     : high in GRANT or RELEASE
//   o_timeout  : one-cycle pulse when a permit is aborted
//   o_spurious : one-cycle pulse on a completion from a non-granted line
module pmt_scheduler
  import pmt_sched_pkg::*;
#(
  parameter int          N           = 4,
  parameter int unsigned TIMEOUT     = 255,
  parameter int          SYNC_STAGES = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N-1:0]              i_req,
  input  logic [N-1:0]              i_ack_tgl,
  output logic [N-1:0]              o_pmt,
  output logic [pmt_gnt_w(N)-1:0]   o_gnt_id,
  output logic                      o_busy,
  output logic                      o_timeout,
  output logic                      o_spurious
);

  localparam int GW = pmt_gnt_w(N);
  localparam logic [N-1:0] PMT_ONE = {{(N-1){1'b0}}, 1'b1};

  pmt_state_e      state_q, state_d;
  logic [GW-1:0]   ptr_q, ptr_d;
  logic [GW-1:0]   gnt_id_q, gnt_id_d;
  logic [N-1:0]    pmt_q, pmt_d;

  logic [N-1:0]    done;
  logic [N-1:0]    grant_mask;
  logic            done_g;
  logic            to_hit;

  // ---------------------------------------------------------------------
  // Per-stage ack synchronizers
  // ---------------------------------------------------------------------
  for (genvar gi = 0; gi < N; gi++) begin : g_ack
    pmt_ack_sync #(
      .SYNC_STAGES(SYNC_STAGES)
    ) u_ack_sync (
      .clk   (clk),
      .rst   (rst),
      .i_tgl (i_ack_tgl[gi]),
      .o_done(done[gi])
    );
  end

  // ---------------------------------------------------------------------
  // Round-robin pick: rotate the requests so ptr sits at bit 0, then take
  // the lowest set bit and map it back to an absolute index.
  // ---------------------------------------------------------------------
  logic [N-1:0]  req_rot;
  logic          pick_valid;
  logic [GW-1:0] pick_id;

  always_comb begin
    req_rot    = N'({i_req, i_req} >> ptr_q);
    pick_valid = |req_rot;
    pick_id    = '0;
    // Walk downward so the lowest set offset is the one that sticks.
    for (int k = N - 1; k >= 0; k--) begin
      if (req_rot[k]) begin
        pick_id = GW'((int'(ptr_q) + k) % N);
      end
    end
  end

  // Only the granted line may complete; pmt_q is already its one-hot mask.
  assign grant_mask = (state_q == GRANT) ? pmt_q : '0;
  assign done_g     = |(done & grant_mask);
  assign o_spurious = |(done & ~grant_mask);

  // ---------------------------------------------------------------------
  // Optional permit-hold timeout
  // ---------------------------------------------------------------------
`ifdef PMT_SCHED_TIMEOUT_EN
  localparam logic [PMT_SCHED_CNT_W-1:0] TO_LAST = PMT_SCHED_CNT_W'(TIMEOUT - 1);

  logic [PMT_SCHED_CNT_W-1:0] cnt_q, cnt_d;

  // cnt_q is 0 in the first GRANT cycle, so hitting TO_LAST marks the
  // TIMEOUT-th cycle with the permit high.
  always_comb begin
    cnt_d = '0;
    if (state_q == GRANT) begin
      cnt_d = cnt_q + PMT_SCHED_CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign to_hit = (state_q == GRANT) && (cnt_q == TO_LAST);
`else
  // TIMEOUT only matters when the counter exists.
  assign to_hit = (TIMEOUT == 0) && 1'b0;
`endif

  // Completion in the same cycle as expiry wins: no abort pulse.
  assign o_timeout = to_hit && !done_g;

  // ---------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    gnt_id_d = gnt_id_q;
    pmt_d    = pmt_q;
    case (state_q)
      IDLE: begin
        pmt_d = '0;
        if (pick_valid) begin
          state_d  = GRANT;
          gnt_id_d = pick_id;
          pmt_d    = PMT_ONE << pick_id;
        end
      end
      GRANT: begin
        // A falling i_req does not revoke; only completion or expiry ends it.
        if (done_g || to_hit) begin
          state_d = RELEASE;
          pmt_d   = '0;
        end
      end
      RELEASE: begin
        state_d = IDLE;
        pmt_d   = '0;
        ptr_d   = (gnt_id_q == GW'(N - 1)) ? '0 : gnt_id_q + GW'(1);
      end
      default: begin
        state_d = IDLE;
        pmt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      gnt_id_q <= '0;
      pmt_q    <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      gnt_id_q <= gnt_id_d;
      pmt_q    <= pmt_d;
    end
  end

  assign o_pmt    = pmt_q;
  assign o_gnt_id = gnt_id_q;
  assign o_busy   = (state_q == GRANT) || (state_q == RELEASE);

endmodule

// File: tb/tb_pmt_scheduler.sv
// tb_pmt_scheduler
// Scoreboard bench for pmt_scheduler. The stimulus process pushes the
// expected grants (id, permit-high length, zero gap before it), expected
// spurious pulses (o_pmt at the pulse) and expected timeouts into queues;
// the monitor process pops and compares whenever the DUT shows the event.
module tb_pmt_scheduler;

  localparam int N       = 4;
  localparam int TIMEOUT = 10;
  localparam int SYNC    = 2;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [N-1:0] i_req = '0;
  logic [N-1:0] i_ack_tgl = '0;
  logic [N-1:0] o_pmt;
  logic [1:0]   o_gnt_id;
  logic         o_busy;
  logic         o_timeout;
  logic         o_spurious;

  always #5 clk = ~clk;

  pmt_scheduler #(
    .N(N), .TIMEOUT(TIMEOUT), .SYNC_STAGES(SYNC)
  ) dut (
    .clk(clk), .rst(rst_n), .i_req(i_req), .i_ack_tgl(i_ack_tgl),
    .o_pmt(o_pmt), .o_gnt_id(o_gnt_id), .o_busy(o_busy),
    .o_timeout(o_timeout), .o_spurious(o_spurious)
  );

  typedef struct {
    int id;
    int dur;   // expected cycles with o_pmt high; 0 = aborted by reset
    int gap;   // expected zero cycles before the rise; -1 = don't care
  } grant_t;

  grant_t       grant_q[$];
  logic [N-1:0] spur_q[$];
  int           to_q[$];

  int n_checks = 0;
  int n_pass   = 0;
  int spur_seen = 0;
  int to_seen   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Bounded wait for the permit to become high / low.
  task automatic wait_pmt(input bit want_hi, input string name);
    int n = 0;
    while (((o_pmt != '0) != want_hi) && n < 100) begin
      @(negedge clk);
      n++;
    end
    check(name, int'((o_pmt != '0) == want_hi), 1);
  endtask

  // ---------------------------------------------------------------------
  // Monitor
  // ---------------------------------------------------------------------
  initial begin : monitor
    logic [N-1:0] prev;
    int           hi;
    int           lo;
    bit           after_fall;
    grant_t       cur;
    prev = '0; hi = 0; lo = 0; after_fall = 1'b0; cur = '{-1, 0, -1};
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev = '0; hi = 0; lo = 0; after_fall = 1'b0;
        continue;
      end
      if (prev == '0 && o_pmt != '0) begin
        check("grant_expected", int'(grant_q.size() > 0), 1);
        if (grant_q.size() > 0) begin
          cur = grant_q.pop_front();
          check("pmt_onehot", int'(o_pmt), 1 << cur.id);
          check("gnt_id", int'(o_gnt_id), cur.id);
          check("busy_grant", int'(o_busy), 1);
          if (cur.gap >= 0) check("zero_gap", lo, cur.gap);
          $display("grant id=%0d pmt=%b t=%0t", o_gnt_id, o_pmt, $time);
        end
        hi = 1;
      end else if (o_pmt != '0) begin
        hi++;
      end
      if (prev != '0 && o_pmt == '0) begin
        if (cur.dur > 0) check("pmt_high_cycles", hi, cur.dur);
        check("busy_release", int'(o_busy), 1);
        $display("release id=%0d held=%0d t=%0t", cur.id, hi, $time);
        after_fall = 1'b1;
        lo = 0;
      end else if (after_fall) begin
        check("busy_idle", int'(o_busy), 0);
        after_fall = 1'b0;
      end
      if (o_pmt == '0) lo++;
      if (o_spurious) begin
        spur_seen++;
        check("spurious_expected", int'(spur_q.size() > 0), 1);
        if (spur_q.size() > 0) check("pmt_at_spurious", int'(o_pmt), int'(spur_q.pop_front()));
        $display("spurious pmt=%b t=%0t", o_pmt, $time);
      end
      if (o_timeout) begin
        to_seen++;
        check("timeout_expected", int'(to_q.size() > 0), 1);
        if (to_q.size() > 0) check("pmt_at_timeout", int'(o_pmt), 1 << to_q.pop_front());
        check("timeout_cycle", hi, TIMEOUT);
        $display("timeout pmt=%b held=%0d t=%0t", o_pmt, hi, $time);
      end
      prev = o_pmt;
    end
  end

  // ---------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------
  initial begin : stim
    // Reset values while rst is held low.
    #1;
    check("rst_pmt", int'(o_pmt), 0);
    check("rst_gnt_id", int'(o_gnt_id), 0);
    check("rst_busy", int'(o_busy), 0);
    check("rst_timeout", int'(o_timeout), 0);
    check("rst_spurious", int'(o_spurious), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // No requests for 20 cycles.
    repeat (20) @(negedge clk);
    check("idle_pmt", int'(o_pmt), 0);
    check("idle_busy", int'(o_busy), 0);
    check("idle_pulses", spur_seen + to_seen, 0);

    // All requesting, prompt acks: order 0,1,2,3,0, 4-cycle permits,
    // two zero cycles (RELEASE + IDLE) between permits.
    for (int k = 0; k < 5; k++) grant_q.push_back('{k % N, 4, (k == 0) ? -1 : 2});
    i_req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      wait_pmt(1'b1, "rr_rise");
      i_ack_tgl ^= o_pmt;
      if (k == 4) i_req = '0;
      wait_pmt(1'b0, "rr_fall");
    end
    repeat (3) @(negedge clk);

    // Single request on 2, request withdrawn during GRANT, ack 3 cycles
    // after the rise -> 7 cycles high; a second toggle lands in IDLE.
    grant_q.push_back('{2, 7, -1});
    spur_q.push_back(4'b0000);
    i_req = 4'b0100;
    wait_pmt(1'b1, "single_rise");
    i_req = '0;
    repeat (3) @(negedge clk);
    i_ack_tgl[2] ^= 1'b1;
    repeat (2) @(negedge clk);
    i_ack_tgl[2] ^= 1'b1;
    wait_pmt(1'b0, "single_fall");
    repeat (4) @(negedge clk);

    // Grant to 0 (wraps from ptr 3); stage 3 toggles mid-permit.
    grant_q.push_back('{0, 9, -1});
    spur_q.push_back(4'b0001);
    i_req = 4'b0001;
    wait_pmt(1'b1, "spur_rise");
    i_req = '0;
    @(negedge clk);
    i_ack_tgl[3] ^= 1'b1;
    repeat (4) @(negedge clk);
    i_ack_tgl[0] ^= 1'b1;
    wait_pmt(1'b0, "spur_fall");
    repeat (3) @(negedge clk);

`ifdef PMT_SCHED_TIMEOUT_EN
    // No ack from 1: permit held TIMEOUT cycles, then ptr moves past 1.
    grant_q.push_back('{1, TIMEOUT, -1});
    to_q.push_back(1);
    i_req = 4'b0010;
    wait_pmt(1'b1, "to_rise");
    i_req = '0;
    wait_pmt(1'b0, "to_fall");
    @(negedge clk);
    grant_q.push_back('{0, 4, -1});
    i_req = 4'b0011;
    wait_pmt(1'b1, "after_to_rise");
    i_ack_tgl ^= o_pmt;
    i_req = '0;
    wait_pmt(1'b0, "after_to_fall");
    repeat (3) @(negedge clk);
`endif

    // Leave ptr at 3, then reset in the middle of a grant to 3.
    grant_q.push_back('{2, 4, -1});
    i_req = 4'b0100;
    wait_pmt(1'b1, "pre_rst_rise");
    i_ack_tgl ^= o_pmt;
    i_req = '0;
    wait_pmt(1'b0, "pre_rst_fall");
    repeat (2) @(negedge clk);
    grant_q.push_back('{3, 0, -1});
    i_req = 4'b1000;
    wait_pmt(1'b1, "rst_grant_rise");
    repeat (2) @(negedge clk);
    #2;
    rst_n = 1'b0;
    i_ack_tgl = '0;
    #1;
    check("async_rst_pmt", int'(o_pmt), 0);
    check("async_rst_busy", int'(o_busy), 0);
    check("async_rst_gnt_id", int'(o_gnt_id), 0);
    i_req = 4'b1010;
    repeat (2) @(negedge clk);
    // ptr restarts at 0, so 1 wins over 3; then 3 follows.
    grant_q.push_back('{1, 4, -1});
    grant_q.push_back('{3, 4, 2});
    rst_n = 1'b1;
    wait_pmt(1'b1, "post_rst_rise1");
    i_req = 4'b1000;
    i_ack_tgl ^= o_pmt;
    wait_pmt(1'b0, "post_rst_fall1");
    wait_pmt(1'b1, "post_rst_rise3");
    i_ack_tgl ^= o_pmt;
    i_req = '0;
    wait_pmt(1'b0, "post_rst_fall3");
    repeat (4) @(negedge clk);

    check("grant_q_empty", grant_q.size(), 0);
    check("spur_q_empty", spur_q.size(), 0);
    check("to_q_empty", to_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, got t=%0t expected < 200000", $time);
    $fatal(1, "watchdog");
  end

endmodule
